// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding, BCD correction constants and a width helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_ADJ_THR = 4'd8;
    localparam logic [3:0] BCD_ADJ_SUB = 4'd3;

    // Smallest binary width that can hold 10**digits - 1.
    function automatic int max_bin_w(input int digits);
        longint v;
        int     w;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        v = v - 1;
        w = 0;
        while (v > 0) begin
            v = v >> 1;
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_sub3_cell.sv
// One-digit reverse double-dabble correction: subtract 3 when the
// shifted digit is >= 8. Ports: in_nib (shifted digit), out_nib (corrected).
module bcd_sub3_cell
    import bcd_pkg::*;
(
    input  logic [3:0] in_nib,
    output logic [3:0] out_nib
);

    always_comb begin
        out_nib = in_nib;
        if (in_nib >= BCD_ADJ_THR) begin
            out_nib = in_nib - BCD_ADJ_SUB;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit/cycle).
// Ports: clk, rst (sync, high), start/bcd_in in; busy, done, err, bin_out out.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    import bcd_pkg::*;

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    // A too-narrow result would leave residue in the BCD part of work.
    if (BIN_W < max_bin_w(DIGITS)) begin : g_width_check
        $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
    end

    state_e              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [BIN_W-1:0]    bin_q, bin_d;

    logic [WORK_W-1:0]   shifted;
    logic [BCD_W-1:0]    bcd_corr;
    logic [WORK_W-1:0]   work_next;
    logic                bad_digit;

    assign shifted = work_q >> 1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_cell
        bcd_sub3_cell u_cell (
            .in_nib  (shifted[BIN_W + 4*i +: 4]),
            .out_nib (bcd_corr[4*i +: 4])
        );
    end

    assign work_next = {bcd_corr, shifted[BIN_W-1:0]};

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > BCD_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        bin_d   = bin_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d = '0;
                    cnt_d = '0;
                    if (bad_digit) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        work_d  = {bcd_in, {BIN_W{1'b0}}};
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = work_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    bin_d   = work_next[BIN_W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: vector table, corner
// sequences (ignored start, mid-run reset) and a random sweep.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [13:0] bin_out;

    int n_chk;
    int n_err;

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        int          exp_bin;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one start; optionally re-pulse start with 8888 at cycle poke.
    task automatic run_conv(input logic [15:0] bcd, input int exp_bin,
                            input bit exp_err, input int poke,
                            input string name);
        int k;
        bit busy_ok;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = bcd;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'h5A5A;
        k = 1;
        busy_ok = 1'b1;
        while (!done && k < 40) begin
            if (!exp_err && busy !== 1'b1) busy_ok = 1'b0;
            if (poke > 0 && k == poke) begin
                start  = 1'b1;
                bcd_in = 16'h8888;
            end else begin
                start  = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({name, " latency"}, k, exp_err ? 1 : 15);
        chk({name, " busy_during"}, int'(busy_ok), 1);
        chk({name, " busy_at_done"}, int'(busy), 0);
        chk({name, " bin_out"}, int'(bin_out), exp_bin);
        chk({name, " err"}, int'(err), int'(exp_err));
    endtask

    vec_t vecs[10];

    initial begin
        int v;
        logic [15:0] b;
        bit saw;
        n_chk  = 0;
        n_err  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 16'h0000;

        vecs[0] = '{16'h0000, 0,    1'b0};
        vecs[1] = '{16'h9999, 9999, 1'b0};
        vecs[2] = '{16'h1234, 1234, 1'b0};
        vecs[3] = '{16'h0507, 507,  1'b0};
        vecs[4] = '{16'h12A4, 0,    1'b1};
        vecs[5] = '{16'h0042, 42,   1'b0};
        vecs[6] = '{16'hF000, 0,    1'b1};
        vecs[7] = '{16'h0009, 9,    1'b0};
        vecs[8] = '{16'h000A, 0,    1'b1};
        vecs[9] = '{16'h8000, 8000, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        chk("reset bin_out", int'(bin_out), 0);
        rst = 1'b0;

        // Table, applied back-to-back (start in the cycle after done).
        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err, 0,
                     $sformatf("vec%0d", i));
        end

        // start during SHIFT must be ignored.
        run_conv(16'h0100, 100, 1'b0, 3, "start_in_shift");

        // start during DONE must be ignored.
        start  = 1'b1;
        bcd_in = 16'h8888;
        @(negedge clk);
        start  = 1'b0;
        chk("done_start busy", int'(busy), 0);
        chk("done_start done", int'(done), 0);
        @(negedge clk);
        chk("done_start busy2", int'(busy), 0);
        chk("done_start hold", int'(bin_out), 100);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h4321;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst err", int'(err), 0);
        chk("midrst bin_out", int'(bin_out), 0);
        rst = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        chk("midrst no_activity", int'(saw), 0);
        run_conv(16'h0321, 321, 1'b0, 0, "after_rst");

        // Random sweep; expected value is the decimal number itself.
        for (int r = 0; r < 20; r++) begin
            v = $urandom_range(0, 9999);
            b[3:0]   = 4'(v % 10);
            b[7:4]   = 4'((v / 10) % 10);
            b[11:8]  = 4'((v / 100) % 10);
            b[15:12] = 4'(v / 1000);
            run_conv(b, v, 1'b0, 0, $sformatf("rand%0d_%0d", r, v));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
